rr_grant_sched_8: RTL
=====================

Name: rr_grant_sched_8

Overview:
- Round-robin arbiter/scheduler that shares one 8-way resource among 8 requesters.
- Produces a registered one-hot grant using the team's MSB-first one-hot convention: requester index i maps to vector bit (7-i). Index 0 is bit 7 and index 7 is bit 0.
- Sits in front of any resource whose select is driven by a 3-bit index or an 8-bit one-hot enable.
- Bounds the hold time per grant with a watchdog timer.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant. 0 disables the limit. Legal range 0..255.
- CNT_W, 8, width of the internal hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  arbitration enable. When 0, no new grants are issued; a grant already held continues.
- req  in  8  request vector. Bit (7-i) = requester i.
- gnt  out  8  registered one-hot grant, same bit mapping as req. All zeros when no grant is held.
- gnt_idx  out  3  index of the current owner. Valid only when gnt_valid=1.
- gnt_valid  out  1  1 while any grant is held.
- timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (rst=1 at a clk edge): gnt=8'b00000000, gnt_idx=3'd0, gnt_valid=0, timeout=0, state=IDLE, hold counter=0, priority pointer ptr=3'd0 (requester 0 highest priority). Reset overrides everything, including an active grant: gnt clears in the cycle after rst is sampled.
- States: IDLE and GRANT.
- IDLE:
  - If en=1 and req!=0, select the first requester with its request set, searching index ptr, ptr+1, …, ptr+7 (mod 8).
  - At the next edge: state=GRANT, gnt=one-hot of the winner (bit 7-winner), gnt_idx=winner, gnt_valid=1, hold counter=1, ptr=winner+1 (mod 8; 7 wraps to 0).
  - If en=0 or req=0, stay in IDLE with outputs zero.
- GRANT: the owner's request bit is sampled every cycle. Release happens when either:
  - (a) the owner's req bit is 0, or
  - (b) MAX_HOLD!=0 and hold counter==MAX_HOLD.
  On release: next edge state=IDLE, gnt=0, gnt_valid=0, hold counter=0. Otherwise the hold counter increments, saturating at its maximum.
- timeout:
  - Asserted for exactly one cycle, coincident with the first gnt=0 cycle, when release was caused by (b) and not (a).
  - If (a) and (b) occur in the same cycle, this is a normal release and timeout=0.
- Latency: request to grant is one cycle from IDLE. After a release there is always exactly one IDLE cycle (gnt=0) before the next grant, so grant-to-grant spacing is at least 1 dead cycle. There is no back-to-back handover.
- Requests from non-owners never affect the current grant. Changes to requests from other requesters during GRANT are ignored until IDLE.
- en falling during GRANT has no effect on the current grant; it only blocks the next arbitration.
- gnt is always one-hot or zero. gnt_idx holds its last value while gnt_valid=0.
- Fairness: with all 8 requesting continuously, grants rotate 0,1,2,…,7,0 (gnt bit 7,6,…,0,7).
- A force-released requester that keeps requesting is re-granted only after every other active requester. ptr has already advanced past it.

Test Plan:
- Reset then single request: rst=1 for 2 cycles, then req=8'b00100000 (requester 2), en=1 → gnt=8'b00100000, gnt_idx=2, gnt_valid=1 one cycle after req is sampled. Drop req → gnt=0 one cycle later, timeout=0.
- Round-robin rotation: req=8'hFF held; each owner drops its req for one cycle after 3 cycles of grant, then reasserts → grant order 0,1,…,7,0. gnt sequence 80,40,20,10,08,04,02,01,80 hex, with exactly one gnt=0 cycle between consecutive grants.
- Timeout: MAX_HOLD=4, req=8'b00000001 (requester 7) held forever → gnt=8'b00000001 for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle, then re-grant of requester 7 (only requester active).
- Timeout fairness: MAX_HOLD=4, req=8'b10000001 held → grants alternate requester 0 and requester 7, each lasting 4 cycles, with a timeout pulse after each.
- Enable gating: requester 3 granted, en=0 asserted mid-grant → grant continues until req bit 4 drops. Afterwards gnt stays 0 with other requests pending until en=1; the next grant then appears one cycle later.
- Reset mid-grant: requester 5 owns gnt=8'b00000100, rst=1 for 1 cycle → gnt=0, gnt_valid=0, timeout=0. With req=8'hFF afterwards, the next grant is requester 0 (ptr reset to 0).

Source files
------------

// File: rtl/rr_grant_sched_8_if.sv
// Request/grant bundle for the 8-way round-robin scheduler.
// Requester i sits on vector bit (7-i) in both req and gnt.
interface rr_grant_sched_8_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_grant_sched_8.sv
// 8-way round-robin grant scheduler with a hold watchdog.
// Registered one-hot grant, MSB-first: requester i is bit (7-i).
module rr_grant_sched_8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    rr_grant_sched_8_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LIM    = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CMAX   = '1;
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam bit               LIM_EN = (MAX_HOLD != 0);

    state_t           state_q, state_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             vld_q, vld_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ptr_q, ptr_d;

    logic [7:0]       req_idx;
    logic             found;
    logic [2:0]       win;
    logic [2:0]       cand;
    logic             own_drop;
    logic             hit;

    // Re-order requests so that bit i belongs to requester i.
    always_comb begin
        req_idx = '0;
        for (int i = 0; i < 8; i++) begin
            req_idx[i] = bus.req[7-i];
        end
    end

    // First active requester at or after the priority pointer.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!found && req_idx[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Release causes: owner dropped its request, or the hold limit hit.
    always_comb begin
        own_drop = !req_idx[idx_q];
        hit      = LIM_EN && (cnt_q == LIM);
    end

    // Next-state and next-output logic of the IDLE/GRANT machine.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        to_d    = 1'b0;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                vld_d = 1'b0;
                cnt_d = '0;
                if (bus.en && found) begin
                    state_d = GRANT;
                    gnt_d   = 8'h80 >> win;
                    idx_d   = win;
                    vld_d   = 1'b1;
                    cnt_d   = ONE;
                    ptr_d   = win + 3'd1;
                end
            end
            GRANT: begin
                if (own_drop || hit) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    cnt_d   = '0;
                    to_d    = hit && !own_drop;
                end else if (cnt_q != CMAX) begin
                    cnt_d = cnt_q + ONE;
                end
            end
        endcase
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = vld_q;
    assign bus.timeout   = to_q;

endmodule
